spi_frame_master: RTL and testbench

//  SPI mode-0 master that sends fixed-length frames (default 40 bit, MSB first) and captures MISO in parallel.
//  It is the initiator end of the FPGA's 40-bit DDS SPI slave link (ESP32 role).

---
 rtl/spi_frame_master.sv | 153 +++++++++++++++
 tb/tb_spi_frame_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: shifts a FRAME_BITS word out MSB first on MOSI while
// capturing MISO, with programmable SCLK divider and CS setup/hold/gap timing.
module spi_frame_master #(
  parameter int FRAME_BITS = 40,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_cs_o,
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int BW    = $clog2(FRAME_BITS + 1);
  localparam int M1    = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2    = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int T_MAX = (M1 > M2) ? M1 : M2;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] SETUP_LD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] DIV_LD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(CS_GAP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP} state_t;

  state_t                state_q;
  logic [TW-1:0]         tmr_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [FRAME_BITS-2:0] tx_sr_q;
  logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d, rx_data_q;
  logic                  cs_q, sclk_q, mosi_q, ready_q, busy_q, rx_valid_q;
  logic                  miso_s1_q, miso_s2_q;
  logic                  samp1_q, samp2_q;

  // The MISO level captured by the synchroniser at the SCLK rise reaches the
  // second flop two clocks later; samp1/samp2 track that so any CLK_DIV works.
  always_comb begin
    rx_sr_d = rx_sr_q;
    if (samp2_q) rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], miso_s2_q};
  end

  always_ff @(posedge clk_i) begin
    miso_s1_q <= spi_miso_i;
    miso_s2_q <= miso_s1_q;
    if (rst_i) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      samp1_q    <= 1'b0;
      samp2_q    <= 1'b0;
      // An aborted frame leaves the last good word visible; otherwise clear.
      case (state_q)
        S_SETUP, S_LOW, S_HIGH, S_HOLD: ;
        default: rx_data_q <= '0;
      endcase
    end else begin
      rx_valid_q <= 1'b0;
      samp1_q    <= 1'b0;
      samp2_q    <= samp1_q;
      rx_sr_q    <= rx_sr_d;
      case (state_q)
        S_IDLE: begin
          if (tx_valid_i) begin
            tx_sr_q   <= tx_data_i[FRAME_BITS-2:0];
            mosi_q    <= tx_data_i[FRAME_BITS-1];
            cs_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            tmr_q     <= SETUP_LD;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_q == '0) begin
            tmr_q   <= DIV_LD;
            state_q <= S_LOW;
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_LOW: begin
          if (tmr_q == '0) begin
            tmr_q   <= DIV_LD;
            sclk_q  <= 1'b1;
            samp1_q <= 1'b1;
            state_q <= S_HIGH;
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_HIGH: begin
          if (tmr_q == '0) begin
            sclk_q    <= 1'b0;
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              tmr_q   <= HOLD_LD;
              state_q <= S_HOLD;
            end else begin
              mosi_q  <= tx_sr_q[FRAME_BITS-2];
              tx_sr_q <= tx_sr_q << 1;
              tmr_q   <= DIV_LD;
              state_q <= S_LOW;
            end
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_HOLD: begin
          if (tmr_q == '0) begin
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= rx_sr_d;
            rx_valid_q <= 1'b1;
            tmr_q      <= GAP_LD;
            state_q    <= S_GAP;
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_GAP: begin
          if (tmr_q == '0) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else tmr_q <= tmr_q - TW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_cs_o   = cs_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: default 40-bit instance plus a fast 8-bit instance,
// checked against an arithmetic timing model and bit-level MOSI/MISO records.
module tb_spi_frame_master;

  localparam int DFB = 40, DDIV = 4, DSET = 2, DHOLD = 2, DGAP = 4;
  localparam int SFB = 8,  SDIV = 1, SSET = 1, SHOLD = 1, SGAP = 1;

  typedef struct {
    logic [63:0] tx;
    int          mode;   // 0 loopback, 1 MISO tied 1, 2 MISO tied 0, 3 random
    logic [63:0] exp_rx;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        tx_valid = 1'b0;
  logic [63:0] tx_word  = '0;
  logic        sel      = 1'b0;
  logic        loop_en  = 1'b1;
  logic        miso_drv = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic           d_ready, d_rx_valid, d_busy, d_cs, d_sclk, d_mosi, d_miso;
  logic [DFB-1:0] d_rx;
  logic           s_ready, s_rx_valid, s_busy, s_cs, s_sclk, s_mosi, s_miso;
  logic [SFB-1:0] s_rx;

  assign d_miso = loop_en ? d_mosi : miso_drv;
  assign s_miso = loop_en ? s_mosi : miso_drv;

  spi_frame_master u_dut (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_word[DFB-1:0]), .tx_valid_i(tx_valid & ~sel),
    .tx_ready_o(d_ready), .rx_data_o(d_rx), .rx_valid_o(d_rx_valid), .busy_o(d_busy),
    .spi_cs_o(d_cs), .spi_sclk_o(d_sclk), .spi_mosi_o(d_mosi), .spi_miso_i(d_miso)
  );

  spi_frame_master #(
    .FRAME_BITS(SFB), .CLK_DIV(SDIV), .CS_SETUP(SSET), .CS_HOLD(SHOLD), .CS_GAP(SGAP)
  ) u_fast (
    .clk_i(clk), .rst_i(rst), .tx_data_i(tx_word[SFB-1:0]), .tx_valid_i(tx_valid & sel),
    .tx_ready_o(s_ready), .rx_data_o(s_rx), .rx_valid_o(s_rx_valid), .busy_o(s_busy),
    .spi_cs_o(s_cs), .spi_sclk_o(s_sclk), .spi_mosi_o(s_mosi), .spi_miso_i(s_miso)
  );

  logic        m_cs, m_sclk, m_mosi, m_miso, m_rx_valid, m_ready;
  logic [63:0] m_rx;
  assign m_cs       = sel ? s_cs : d_cs;
  assign m_sclk     = sel ? s_sclk : d_sclk;
  assign m_mosi     = sel ? s_mosi : d_mosi;
  assign m_miso     = sel ? s_miso : d_miso;
  assign m_rx_valid = sel ? s_rx_valid : d_rx_valid;
  assign m_ready    = sel ? s_ready : d_ready;
  assign m_rx       = sel ? 64'(s_rx) : 64'(d_rx);

  function automatic int fb_of(input logic s);
    return s ? SFB : DFB;
  endfunction
  function automatic int div_of(input logic s);
    return s ? SDIV : DDIV;
  endfunction
  function automatic int gap_of(input logic s);
    return s ? SGAP : DGAP;
  endfunction
  function automatic int cs_low_of(input logic s);
    return s ? (SSET + 2 * SDIV * SFB + SHOLD) : (DSET + 2 * DDIV * DFB + DHOLD);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Runs one frame on the selected instance and checks it against the model.
  task automatic run_frame(input logic [63:0] word, input int mode, input bit use_tbl,
                           input logic [63:0] exp_rx, input bit hold,
                           input logic [63:0] next_word, input string tag, output int gap);
    int fb, div, n, rises, cs_low, vpul, mosi_err, per_err, idle_err, idx, cyc, last_rise;
    logic prev_sclk, v_at_rise, ready_end;
    logic [63:0] mosi_got, model, mask, rx_end;
    fb = fb_of(sel);
    div = div_of(sel);
    mask = (fb == 64) ? '1 : ((64'd1 << fb) - 64'd1);
    loop_en = (mode == 0);
    miso_drv = (mode == 1);
    tx_word = word;
    tx_valid = 1'b1;
    n = 0;
    while (m_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accept"}, 64'(m_cs), 64'd0);
    if (hold) tx_word = next_word;
    else tx_valid = 1'b0;
    rises = 0; cs_low = 0; vpul = 0; mosi_err = 0; per_err = 0; idle_err = 0;
    cyc = 0; last_rise = 0; prev_sclk = 1'b0; mosi_got = '0; model = '0;
    while (!m_cs && cs_low < 4 * cs_low_of(sel)) begin
      cs_low++;
      cyc++;
      if (m_rx_valid) vpul++;
      if (m_sclk && !prev_sclk) begin
        rises++;
        mosi_got = {mosi_got[62:0], m_mosi};
        model = {model[62:0], m_miso};
        if (rises > 1 && (cyc - last_rise) != 2 * div) per_err++;
        last_rise = cyc;
      end
      idx = m_sclk ? rises - 1 : ((rises < fb) ? rises : fb - 1);
      if (idx < 0) idx = 0;
      if (m_mosi !== word[fb-1-idx]) mosi_err++;
      prev_sclk = m_sclk;
      if (mode == 3) miso_drv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    v_at_rise = m_rx_valid;
    rx_end = m_rx;
    gap = 0;
    while (m_cs && gap < gap_of(sel) + 3) begin
      gap++;
      if (m_rx_valid) vpul++;
      if (m_sclk || m_mosi) idle_err++;
      @(negedge clk);
    end
    ready_end = m_ready;
    chk({tag, " rises"}, 64'(rises), 64'(fb));
    chk({tag, " cs_low"}, 64'(cs_low), 64'(cs_low_of(sel)));
    chk({tag, " mosi_word"}, mosi_got & mask, word & mask);
    chk({tag, " mosi_err"}, 64'(mosi_err), 64'd0);
    chk({tag, " sclk_period"}, 64'(per_err), 64'd0);
    chk({tag, " valid_at_cs_rise"}, 64'(v_at_rise), 64'd1);
    chk({tag, " valid_pulses"}, 64'(vpul), 64'd1);
    chk({tag, " idle_lines"}, 64'(idle_err), 64'd0);
    chk({tag, " rx_data"}, rx_end, use_tbl ? (exp_rx & mask) : (model & mask));
    if (!hold) chk({tag, " ready_after"}, 64'(ready_end), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[5];
    int          gap, n, rises, vp, lowc;
    logic        prev;
    logic [63:0] w;
    int          m;

    tbl[0] = '{64'hA5_1234_5678, 0, 64'hA5_1234_5678};
    tbl[1] = '{64'h0,            1, 64'hFF_FFFF_FFFF};
    tbl[2] = '{64'hFF_FFFF_FFFF, 2, 64'h0};
    tbl[3] = '{64'h5A_F00F_C3C3, 0, 64'h5A_F00F_C3C3};
    tbl[4] = '{64'h80_0000_0001, 1, 64'hFF_FFFF_FFFF};

    // Reset with tx_valid asserted: nothing may be accepted.
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_word = 64'h12_3456_789A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("reset cs", 64'(d_cs), 64'd1);
    chk("reset sclk", 64'(d_sclk), 64'd0);
    chk("reset mosi", 64'(d_mosi), 64'd0);
    chk("reset ready", 64'(d_ready), 64'd1);
    chk("reset rx_valid", 64'(d_rx_valid), 64'd0);
    chk("reset busy", 64'(d_busy), 64'd0);
    chk("reset rx_data", 64'(d_rx), 64'd0);
    chk("reset fast cs", 64'(s_cs), 64'd1);

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].tx, tbl[i].mode, 1'b1, tbl[i].exp_rx, 1'b0, '0, $sformatf("tbl%0d", i), gap);

    // Back-to-back with tx_valid held: second word must wait for ready.
    run_frame(64'h1, 0, 1'b1, 64'h1, 1'b1, 64'hFF_FFFF_FFFF, "b2b_first", gap);
    chk("b2b cs_high_cycles", 64'(gap), 64'(DGAP + 1));
    run_frame(64'hFF_FFFF_FFFF, 0, 1'b1, 64'hFF_FFFF_FFFF, 1'b0, '0, "b2b_second", gap);

    // Reset after the 17th SCLK rise aborts the frame silently.
    loop_en = 1'b1;
    tx_word = {32'h0, $urandom} | 64'h55_0000_0000;
    tx_valid = 1'b1;
    n = 0;
    while (d_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    rises = 0;
    prev = 1'b0;
    n = 0;
    while (rises < 17 && n < 2000) begin
      @(negedge clk);
      n++;
      if (d_sclk && !prev) rises++;
      prev = d_sclk;
    end
    chk("abort reached_rise17", 64'(rises), 64'd17);
    rst = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("abort cs", 64'(d_cs), 64'd1);
    chk("abort sclk", 64'(d_sclk), 64'd0);
    chk("abort mosi", 64'(d_mosi), 64'd0);
    chk("abort ready", 64'(d_ready), 64'd1);
    rst = 1'b0;
    tx_valid = 1'b0;
    vp = 0;
    lowc = 0;
    repeat (40) begin
      @(negedge clk);
      if (d_rx_valid) vp++;
      if (!d_cs) lowc++;
    end
    chk("abort rx_valid_pulses", 64'(vp), 64'd0);
    chk("abort cs_low_after", 64'(lowc), 64'd0);
    chk("abort rx_data_kept", 64'(d_rx), 64'hFF_FFFF_FFFF);

    for (int i = 0; i < 6; i++) begin
      w = {24'h0, 8'($urandom), $urandom};
      m = (i == 0) ? 0 : int'($urandom_range(0, 3));
      run_frame(w, m, 1'b0, '0, 1'b0, '0, $sformatf("rand%0d", i), gap);
    end

    // Fast instance: CLK_DIV=1, 8-bit frames, unit CS timing.
    sel = 1'b1;
    run_frame(64'h81, 0, 1'b1, 64'h81, 1'b0, '0, "fast81", gap);
    for (int i = 0; i < 10; i++) begin
      w = 64'($urandom_range(0, 255));
      m = int'($urandom_range(0, 3));
      run_frame(w, m, 1'b0, '0, 1'b0, '0, $sformatf("fastrand%0d", i), gap);
    end
    run_frame(64'h3C, 0, 1'b1, 64'h3C, 1'b1, 64'hA7, "fast_b2b_first", gap);
    chk("fast b2b cs_high_cycles", 64'(gap), 64'(SGAP + 1));
    run_frame(64'hA7, 0, 1'b1, 64'hA7, 1'b0, '0, "fast_b2b_second", gap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
